// File: rtl/aclk_core.sv
// aclk_core: 24-hour BCD alarm clock with validated time/alarm loads
// and a sticky alarm flag raised on an HH:MM:00 match.
module aclk_core #(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       AL_ON,
    input  logic       STOP_al,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0,
    output logic       Alarm
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] pre;
    logic [1:0] a_h1;
    logic [3:0] a_h0, a_m1, a_m0;
    logic [1:0] n_h1;
    logic [3:0] n_h0, n_m1, n_m0, n_s1, n_s0;
    logic tick, valid, ld_t, ld_a, c_s0, c_s1, c_m0, c_m1, h_wrap, match;

    assign tick = pre == LAST;
    assign valid = H_in1 <= 2'd2 && H_in0 <= 4'd9 && !(H_in1 == 2'd2 && H_in0 > 4'd3)
                   && M_in1 <= 4'd5 && M_in0 <= 4'd9;
    assign ld_t = LD_time && valid;
    assign ld_a = LD_alarm && valid;

    // Ripple BCD carry chain; a load overrides the increment, no tick holds time.
    always_comb begin
        c_s0   = S_out0 == 4'd9;
        c_s1   = c_s0 && S_out1 == 4'd5;
        c_m0   = c_s1 && M_out0 == 4'd9;
        c_m1   = c_m0 && M_out1 == 4'd5;
        h_wrap = H_out1 == 2'd2 && H_out0 == 4'd3;
        n_s0   = c_s0 ? 4'd0 : S_out0 + 4'd1;
        n_s1   = c_s1 ? 4'd0 : c_s0 ? S_out1 + 4'd1 : S_out1;
        n_m0   = c_m0 ? 4'd0 : c_s1 ? M_out0 + 4'd1 : M_out0;
        n_m1   = c_m1 ? 4'd0 : c_m0 ? M_out1 + 4'd1 : M_out1;
        n_h0   = !c_m1 ? H_out0 : (h_wrap || H_out0 == 4'd9) ? 4'd0 : H_out0 + 4'd1;
        n_h1   = !c_m1 ? H_out1 : h_wrap ? 2'd0 : H_out0 == 4'd9 ? H_out1 + 2'd1 : H_out1;
        if (ld_t) begin
            {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0} = {H_in1, H_in0, M_in1, M_in0, 8'd0};
        end else if (!tick) begin
            {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0} = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
        end
        match = (ld_t || tick) &&
                {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0} == {a_h1, a_h0, a_m1, a_m0, 8'd0};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre <= '0;
            {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} <= '0;
            {a_h1, a_h0, a_m1, a_m0} <= '0;
            Alarm <= 1'b0;
        end else begin
            pre <= (ld_t || tick) ? '0 : pre + PW'(1);
            {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} <= {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
            if (ld_a)
                {a_h1, a_h0, a_m1, a_m0} <= {H_in1, H_in0, M_in1, M_in0};
            Alarm <= (STOP_al || !AL_ON) ? 1'b0 : match ? 1'b1 : Alarm;
        end
    end
endmodule
